// File: rtl/ks_audio_pkg.sv
// ============================================================================
// ks_audio_pkg -- shared widths, saturation limits and helpers for the I2S path
// Revision: 1.0
// ============================================================================
`default_nettype none

package ks_audio_pkg;

  localparam int OUT_W      = 24;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int SAT_MAX    = 8388607;
  localparam int SAT_MIN    = -8388608;

  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_IDX_W = $clog2(SLOT_BITS);

  // Attenuate, clamp to the 24-bit output range, then apply mute.
  function automatic logic [OUT_W-1:0] scale_sample(input logic [31:0] din,
                                                    input logic [3:0]  vol,
                                                    input logic        mute);
    logic signed [31:0] s;
    s = $signed(din) >>> vol;
    if (mute)
      return '0;
    if (s > SAT_MAX)
      return OUT_W'(SAT_MAX);
    if (s < SAT_MIN)
      return OUT_W'(SAT_MIN);
    return s[OUT_W-1:0];
  endfunction

  // Bit of the slot word for the new bit position b; (b-1) gives the
  // one-bclk MSB delay relative to the word-select edge.
  function automatic logic slot_bit(input logic [OUT_W-1:0] smp,
                                    input logic [BIT_W-1:0] b);
    logic [SLOT_BITS-1:0]  word;
    logic [BIT_W-1:0]      pos;
    logic [SLOT_IDX_W-1:0] idx;
    word = {smp, {(SLOT_BITS - OUT_W){1'b0}}};
    pos  = b - BIT_W'(1);
    idx  = pos[SLOT_IDX_W-1:0];
    return word[SLOT_IDX_W'(SLOT_BITS - 1) - idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks_sample_fifo.sv
// ============================================================================
// ks_sample_fifo -- synchronous show-ahead sample FIFO with registered level
// Revision: 1.0
// ============================================================================
`default_nettype none

module ks_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ks_i2s_out.sv
// ============================================================================
// ks_i2s_out -- scales samples into a FIFO and serializes them as mono I2S
// Revision: 1.0
// ============================================================================
`default_nettype none

module ks_i2s_out
  import ks_audio_pkg::*;
#(
  parameter int DIV_BCLK   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [3:0]  volume,
  input  logic        mute,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic [3:0]  fifo_level,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam int         LVL_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_BCLK - 1);

  logic [7:0]       div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BIT_W-1:0] b;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       underrun_cnt_q, underrun_cnt_d;
  logic [OUT_W-1:0] sample_q, sample_d;

  logic             push;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_rdata;
  logic [OUT_W-1:0] scaled;
  logic [LVL_W-1:0] fifo_lvl;

  // Ready comes from the registered level only; reset holds the level at 0.
  assign din_ready = !fifo_full;
  assign push      = din_valid && din_ready;
  assign scaled    = scale_sample(din, volume, mute);

  ks_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W),
    .LW    (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (scaled),
    .pop   (pop_req),
    .rdata (fifo_rdata),
    .level (fifo_lvl),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    div_cnt_d      = div_cnt_q + 8'd1;
    bclk_d         = bclk_q;
    bit_cnt_d      = bit_cnt_q;
    lrclk_d        = lrclk_q;
    sdata_d        = sdata_q;
    sample_d       = sample_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    pop_req        = 1'b0;
    b              = bit_cnt_q + BIT_W'(1);
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        bit_cnt_d = b;
        lrclk_d   = b[BIT_W-1];
        // Frame start: fetch one sample, shared by left and right slots.
        if (b == BIT_W'(1)) begin
          pop_req = 1'b1;
          if (fifo_empty) begin
            sample_d   = '0;
            underrun_d = 1'b1;
            if (underrun_cnt_q != 8'hFF)
              underrun_cnt_d = underrun_cnt_q + 8'd1;
          end else begin
            sample_d = fifo_rdata;
          end
        end
        sdata_d = slot_bit(sample_d, b);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      bclk_q         <= 1'b0;
      lrclk_q        <= 1'b0;
      sdata_q        <= 1'b0;
      sample_q       <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      bclk_q         <= bclk_d;
      lrclk_q        <= lrclk_d;
      sdata_q        <= sdata_d;
      sample_q       <= sample_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign fifo_level   = 4'(fifo_lvl);
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

`default_nettype wire
